// File: rtl/linear_fifo.sv
// linear_fifo: synchronous first-word fall-through FIFO with wrap-around
// pointers and optional sticky error flags.
//
// Optional feature macro: LINEAR_FIFO_ERR_FLAGS_EN
//   defined   -> overflow/underflow are sticky registers, cleared only by reset
//   undefined -> overflow/underflow are tied to 0
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   synchronous active-low reset
//   push      in   write request
//   pop       in   read request
//   din       in   write data, sampled on an accepted push
//   dout      out  head entry (combinational read of storage[rd_ptr])
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  number of stored entries
//   overflow  out  sticky: a push was dropped while full
//   underflow out  sticky: a pop was ignored while empty
module linear_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Status decode straight from the occupancy count.
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == CNT_W'(0));

    // A pop frees a slot in the same cycle, so push is accepted while full if
    // the pop goes through. Pop while empty never bypasses a simultaneous push.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign dout = mem[rd_ptr];

    // Pointer and count state; power-of-two depth makes wrap implicit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is intentionally not reset; gated by reset so a push coinciding
    // with reset leaves no trace.
    always_ff @(posedge clk) begin
        if (reset && push_ok) mem[wr_ptr] <= din;
    end

`ifdef LINEAR_FIFO_ERR_FLAGS_EN
    // Sticky error flags; while full, pop_ok equals pop, so !pop_ok marks a drop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full && !pop_ok) overflow  <= 1'b1;
            if (pop && empty)            underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: doc/linear_fifo.md
LINEAR_FIFO -- requirements
Module: linear_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, number of entries; power of two, minimum 2.
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port push, input, 1, write request for the current cycle.
REQ-006 The block SHALL have port pop, input, 1, read request for the current cycle.
REQ-007 The block SHALL have port din, input, WIDTH, write data sampled on an accepted push.
REQ-008 The block SHALL have port dout, output, WIDTH, head entry (first-word fall-through).
REQ-009 The block SHALL have port full, output, 1, high when count equals DEPTH.
REQ-010 The block SHALL have port empty, output, 1, high when count equals 0.
REQ-011 The block SHALL have port count, output, $clog2(DEPTH+1), number of stored entries.
REQ-012 The block SHALL have port overflow, output, 1, error flag (see Configuration).
REQ-013 The block SHALL have port underflow, output, 1, error flag (see Configuration).

Function
REQ-014 The block SHALL accept a push when push=1 and (full=0 or pop is accepted in the same cycle); din is written at wr_ptr, and wr_ptr advances by 1.
REQ-015 The block SHALL accept a pop when pop=1 and empty=0; rd_ptr advances by 1.
REQ-016 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no extra cycle.
REQ-017 count SHALL increase by 1 on push-only, decrease by 1 on pop-only, and stay unchanged on accepted push+pop.
REQ-018 Push while full without pop SHALL be dropped: no pointer, count or storage change.
REQ-019 Pop while empty SHALL be ignored; a simultaneous push while empty SHALL be accepted (no bypass), and the pop has no effect.
REQ-020 dout SHALL equal storage[rd_ptr] combinationally; new data is visible on dout the cycle after the push that filled an empty FIFO.
REQ-021 dout content while empty is don't-care; the bench SHALL NOT check it.
REQ-022 full and empty SHALL be decoded combinationally from count and SHALL never be high together.

Reset
REQ-023 With reset=0 at a rising clk edge, the block SHALL set wr_ptr=0, rd_ptr=0, count=0, overflow=0 and underflow=0, giving full=0 and empty=1; storage contents are not reset.
REQ-024 Reset SHALL take priority over push and pop in the same cycle; a mid-operation reset discards all entries.

Configuration
REQ-025 Macro LINEAR_FIFO_ERR_FLAGS_EN SHALL select the error-flag feature.
REQ-026 With the macro defined, overflow SHALL set one cycle after a dropped push (REQ-018), underflow SHALL set one cycle after an ignored pop while empty (REQ-019), and both flags SHALL stay sticky until reset.
REQ-027 Without the macro, overflow and underflow SHALL be tied to 0 and no flag registers SHALL be synthesised.

Verification
REQ-028 Reset check: hold reset=0 for 5 clocks, then release -> empty=1, full=0, count=0, overflow=0, underflow=0.
REQ-029 Ordering with DEPTH=4: push 8'hA1, 8'hA2, 8'hA3, 8'hA4, then pop 4 times -> full=1 after the 4th push; dout reads A1, A2, A3, A4 in order; empty=1 at the end.
REQ-030 Wrap-around: push 3, pop 3, then push 8'h10..8'h13 -> pointers wrap, dout=8'h10 at head, count=4, full=1.
REQ-031 Simultaneous events: push+pop while full with din=8'h55 -> count stays 4, head advances, 8'h55 is read out 4 pops later; push+pop while empty -> count=1, dout=din.
REQ-032 Errors with the macro defined: push while full -> overflow=1 next cycle and held, count=4; pop while empty -> underflow=1; without the macro, the same stimulus -> both flags stay 0.
REQ-033 Reset mid-operation: load 2 entries, apply reset=0 for 1 clock together with push=1 -> count=0, empty=1, and the push is not stored.
